// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-master memory arbiter.
//   arb_state_t : arbiter FSM states (idle / waiting for memory)
//   owner_t     : identifies the master owning the in-flight request
package mem_arb_pkg;

    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } arb_state_t;

    typedef enum logic {
        OWN_IFU,
        OWN_LSU
    } owner_t;

endpackage

// File: rtl/mem_arb_timer.sv
// WAIT-phase watchdog for the memory arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart counting from zero (issued on each grant)
//   enable     : count this cycle (high for every WAIT cycle)
//   expired    : high during the TIMEOUT_CYCLES-th enabled cycle
module mem_arb_timer
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // count holds the number of WAIT cycles already completed, so the
    // final allowed cycle is the one where it equals TIMEOUT_CYCLES-1.
    assign expired = enable && (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between an instruction
// fetch unit (read only) and a load/store unit. One request in flight.
//   clk, rst_n                      : clock, asynchronous active-low reset
//   ifu_req/ifu_addr                : fetch request pulse and address
//   ifu_rvalid/ifu_rdata/ifu_err    : fetch completion pulse, data, timeout flag
//   lsu_req/wen/addr/wdata/wmask    : load/store request pulse and payload
//   lsu_rvalid/lsu_rdata/lsu_err    : load/store completion pulse, data, timeout flag
//   mem_req/wen/addr/wdata/wmask    : registered request pulse and payload to memory
//   mem_rvalid/mem_rdata            : memory completion pulse and read data
//   busy                            : high while a memory access is outstanding
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ifu_req,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_rvalid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_err,
    input  logic                lsu_req,
    input  logic                lsu_wen,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_rvalid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_err,
    output logic                mem_req,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    arb_state_t          state_q, state_d;
    owner_t              owner_q, owner_d;
    owner_t              last_owner_q, last_owner_d;
    logic                pend_ifu_q, pend_ifu_d;
    logic                pend_lsu_q, pend_lsu_d;

    logic                mem_req_d, mem_wen_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_d;
    logic [DATA_W/8-1:0] mem_wmask_d;
    logic                ifu_rvalid_d, ifu_err_d;
    logic [DATA_W-1:0]   ifu_rdata_d;
    logic                lsu_rvalid_d, lsu_err_d;
    logic [DATA_W-1:0]   lsu_rdata_d;

    logic                want_ifu, want_lsu;
    logic                grant_valid;
    owner_t              grant;
    logic                rsp_valid, rsp_err;
    logic [DATA_W-1:0]   rsp_data;
    logic                timer_clear, timer_enable, timer_expired;

    mem_arb_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    assign busy = (state_q == ST_WAIT);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        // A request always lands in its pending flag; the grant below
        // clears it again when the request is serviced straight away.
        pend_ifu_d   = pend_ifu_q | ifu_req;
        pend_lsu_d   = pend_lsu_q | lsu_req;
        mem_req_d    = 1'b0;
        mem_wen_d    = mem_wen;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        mem_wmask_d  = mem_wmask;
        ifu_rvalid_d = 1'b0;
        ifu_err_d    = 1'b0;
        ifu_rdata_d  = ifu_rdata;
        lsu_rvalid_d = 1'b0;
        lsu_err_d    = 1'b0;
        lsu_rdata_d  = lsu_rdata;
        timer_clear  = 1'b0;
        timer_enable = 1'b0;
        want_ifu     = ifu_req | pend_ifu_q;
        want_lsu     = lsu_req | pend_lsu_q;
        grant_valid  = 1'b0;
        grant        = OWN_IFU;
        rsp_valid    = 1'b0;
        rsp_err      = 1'b0;
        rsp_data     = '0;

        case (state_q)
            ST_IDLE: begin
                // last_owner only moves on a genuine tie, so an uncontested
                // grant does not disturb the alternation between ties.
                if (want_ifu && want_lsu) begin
                    grant_valid  = 1'b1;
                    grant        = (last_owner_q == OWN_IFU) ? OWN_LSU : OWN_IFU;
                    last_owner_d = grant;
                end else if (want_ifu) begin
                    grant_valid = 1'b1;
                    grant       = OWN_IFU;
                end else if (want_lsu) begin
                    grant_valid = 1'b1;
                    grant       = OWN_LSU;
                end

                if (grant_valid) begin
                    state_d     = ST_WAIT;
                    owner_d     = grant;
                    mem_req_d   = 1'b1;
                    timer_clear = 1'b1;
                    if (grant == OWN_IFU) begin
                        pend_ifu_d  = 1'b0;
                        mem_wen_d   = 1'b0;
                        mem_addr_d  = ifu_addr;
                        mem_wdata_d = '0;
                        mem_wmask_d = '0;
                    end else begin
                        pend_lsu_d  = 1'b0;
                        mem_wen_d   = lsu_wen;
                        mem_addr_d  = lsu_addr;
                        mem_wdata_d = lsu_wdata;
                        mem_wmask_d = lsu_wmask;
                    end
                end
            end

            ST_WAIT: begin
                timer_enable = 1'b1;
                // A real response beats a timeout landing in the same cycle.
                if (mem_rvalid) begin
                    rsp_valid = 1'b1;
                    rsp_data  = (owner_q == OWN_LSU && mem_wen) ? '0 : mem_rdata;
                end else if (timer_expired) begin
                    rsp_valid = 1'b1;
                    rsp_err   = 1'b1;
                end

                if (rsp_valid) begin
                    state_d = ST_IDLE;
                    if (owner_q == OWN_IFU) begin
                        ifu_rvalid_d = 1'b1;
                        ifu_err_d    = rsp_err;
                        ifu_rdata_d  = rsp_data;
                    end else begin
                        lsu_rvalid_d = 1'b1;
                        lsu_err_d    = rsp_err;
                        lsu_rdata_d  = rsp_data;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_IFU;
            last_owner_q <= OWN_LSU;
            pend_ifu_q   <= 1'b0;
            pend_lsu_q   <= 1'b0;
            mem_req      <= 1'b0;
            mem_wen      <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wmask    <= '0;
            ifu_rvalid   <= 1'b0;
            ifu_err      <= 1'b0;
            ifu_rdata    <= '0;
            lsu_rvalid   <= 1'b0;
            lsu_err      <= 1'b0;
            lsu_rdata    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            pend_ifu_q   <= pend_ifu_d;
            pend_lsu_q   <= pend_lsu_d;
            mem_req      <= mem_req_d;
            mem_wen      <= mem_wen_d;
            mem_addr     <= mem_addr_d;
            mem_wdata    <= mem_wdata_d;
            mem_wmask    <= mem_wmask_d;
            ifu_rvalid   <= ifu_rvalid_d;
            ifu_err      <= ifu_err_d;
            ifu_rdata    <= ifu_rdata_d;
            lsu_rvalid   <= lsu_rvalid_d;
            lsu_err      <= lsu_err_d;
            lsu_rdata    <= lsu_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// multi-cycle sequences, and a randomized run against a transaction model.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 64;

    logic          clk, rst_n;
    logic          ifu_req;
    logic [AW-1:0] ifu_addr;
    logic          ifu_rvalid;
    logic [DW-1:0] ifu_rdata;
    logic          ifu_err;
    logic          lsu_req, lsu_wen;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata;
    logic [3:0]    lsu_wmask;
    logic          lsu_rvalid;
    logic [DW-1:0] lsu_rdata;
    logic          lsu_err;
    logic          mem_req, mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_wmask;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    int unsigned n_cmp, n_fail, cyc;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
        .lsu_req(lsu_req), .lsu_wen(lsu_wen), .lsu_addr(lsu_addr),
        .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    typedef struct {
        bit          lsu;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int unsigned lat;      // memory latency after mem_req, 0 = never answers
        logic [31:0] mdata;
        bit          x_wen;
        logic [31:0] x_wdata;
        logic [3:0]  x_wmask;
        int unsigned x_lat;    // cycles from req to completion pulse
        logic [31:0] x_rdata;
        bit          x_err;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int unsigned t;
        int unsigned other;
        bit got;
        if (v.lsu) begin
            lsu_req = 1; lsu_wen = v.wen; lsu_addr = v.addr;
            lsu_wdata = v.wdata; lsu_wmask = v.wmask;
        end else begin
            ifu_req = 1; ifu_addr = v.addr;
        end
        tick();
        ifu_req = 0; lsu_req = 0;
        chk({nm, "_mem_req"}, mem_req, 1);
        chk({nm, "_busy"}, busy, 1);
        chk({nm, "_addr"}, mem_addr, v.addr);
        chk({nm, "_wen"}, mem_wen, v.x_wen);
        chk({nm, "_wdata"}, mem_wdata, v.x_wdata);
        chk({nm, "_wmask"}, mem_wmask, v.x_wmask);
        t = 1; got = 0; other = 0;
        while (!got && t < 100) begin
            if (v.lat != 0 && t == 1 + v.lat) begin
                mem_rvalid = 1; mem_rdata = v.mdata;
            end
            tick();
            mem_rvalid = 0; mem_rdata = 32'h0BAD_0BAD;
            t++;
            if (t == 2) chk({nm, "_mem_req_pulse"}, mem_req, 0);
            got = v.lsu ? lsu_rvalid : ifu_rvalid;
            if (v.lsu ? ifu_rvalid : lsu_rvalid) other++;
        end
        chk({nm, "_latency"}, t, v.x_lat);
        chk({nm, "_rdata"}, v.lsu ? lsu_rdata : ifu_rdata, v.x_rdata);
        chk({nm, "_err"}, v.lsu ? lsu_err : ifu_err, v.x_err);
        tick();
        chk({nm, "_rvalid_pulse"}, v.lsu ? lsu_rvalid : ifu_rvalid, 0);
        chk({nm, "_err_pulse"}, v.lsu ? lsu_err : ifu_err, 0);
        chk({nm, "_rdata_hold"}, v.lsu ? lsu_rdata : ifu_rdata, v.x_rdata);
        chk({nm, "_idle"}, busy, 0);
        chk({nm, "_other_master"}, other, 0);
    endtask

    // ---------------- random-phase transaction model ----------------
    bit          i_out, i_iss, i_exp, i_xe;
    bit          l_out, l_iss, l_exp, l_xe, l_w;
    bit          m_busy, m_own, m_never, ok;
    logic [31:0] i_a, i_xd, l_a, l_d, l_xd, m_data;
    logic [3:0]  l_m;
    int unsigned i_due, l_due, i_t0, l_t0, m_resp, spurious, n_done;

    task automatic rnd_step(input bit allow_issue);
        tick();
        ifu_req = 0; lsu_req = 0; mem_rvalid = 0; mem_rdata = $urandom;

        if (ifu_rvalid && i_exp && i_due == cyc) begin
            chk("rnd_ifu_rdata", ifu_rdata, i_xd);
            chk("rnd_ifu_err", ifu_err, i_xe);
            i_exp = 0; i_out = 0; m_busy = 0; n_done++;
        end else if (ifu_rvalid) begin
            spurious++;
        end else if (i_exp && i_due == cyc) begin
            chk("rnd_ifu_missing", ifu_rvalid, 1);
            i_exp = 0; i_out = 0; m_busy = 0;
        end

        if (lsu_rvalid && l_exp && l_due == cyc) begin
            chk("rnd_lsu_rdata", lsu_rdata, l_xd);
            chk("rnd_lsu_err", lsu_err, l_xe);
            l_exp = 0; l_out = 0; m_busy = 0; n_done++;
        end else if (lsu_rvalid) begin
            spurious++;
        end else if (l_exp && l_due == cyc) begin
            chk("rnd_lsu_missing", lsu_rvalid, 1);
            l_exp = 0; l_out = 0; m_busy = 0;
        end

        if (i_out && cyc - i_t0 > 300) begin
            chk("rnd_ifu_starved", cyc - i_t0, 0);
            i_out = 0; i_exp = 0;
        end
        if (l_out && cyc - l_t0 > 300) begin
            chk("rnd_lsu_starved", cyc - l_t0, 0);
            l_out = 0; l_exp = 0;
        end

        if (mem_req) begin
            ok = 0;
            chk("rnd_overlap", m_busy, 0);
            if (i_out && !i_iss && mem_wen == 0 && mem_addr == i_a &&
                mem_wdata == 0 && mem_wmask == 0) begin
                ok = 1; m_own = 0; i_iss = 1;
            end else if (l_out && !l_iss && mem_wen == l_w && mem_addr == l_a &&
                         mem_wdata == l_d && mem_wmask == l_m) begin
                ok = 1; m_own = 1; l_iss = 1;
            end
            chk("rnd_payload", ok, 1);
            if (ok) begin
                m_busy  = 1;
                m_never = ($urandom_range(0, 11) == 0);
                m_resp  = cyc + $urandom_range(1, 4);
                m_data  = $urandom;
                if (m_never) begin
                    if (m_own == 0) begin i_exp = 1; i_due = cyc + TO; i_xd = 0; i_xe = 1; end
                    else            begin l_exp = 1; l_due = cyc + TO; l_xd = 0; l_xe = 1; end
                end
            end
        end else if (m_busy && !m_never && cyc == m_resp) begin
            mem_rvalid = 1; mem_rdata = m_data;
            if (m_own == 0) begin i_exp = 1; i_due = cyc + 1; i_xd = m_data; i_xe = 0; end
            else begin l_exp = 1; l_due = cyc + 1; l_xd = l_w ? 32'h0 : m_data; l_xe = 0; end
        end

        if (allow_issue && !i_out && $urandom_range(0, 2) == 0) begin
            i_out = 1; i_iss = 0; i_t0 = cyc;
            i_a = {4'h0, 26'($urandom), 2'b00};
            ifu_addr = i_a; ifu_req = 1;
        end
        if (allow_issue && !l_out && $urandom_range(0, 2) == 0) begin
            l_out = 1; l_iss = 0; l_t0 = cyc;
            l_w = 1'($urandom_range(0, 1));
            l_a = {4'h8, 26'($urandom), 2'b00};
            l_d = $urandom; l_m = 4'($urandom);
            lsu_wen = l_w; lsu_addr = l_a; lsu_wdata = l_d; lsu_wmask = l_m; lsu_req = 1;
        end
    endtask

    int unsigned extra;

    initial begin
        n_cmp = 0; n_fail = 0; cyc = 0;
        ifu_req = 0; ifu_addr = 0; lsu_req = 0; lsu_wen = 0; lsu_addr = 0;
        lsu_wdata = 0; lsu_wmask = 0; mem_rvalid = 0; mem_rdata = 0;
        rst_n = 1;

        //            lsu wen addr          wdata         wmask lat mdata         xwen xwdata        xwmask xlat xrdata        xerr
        vecs[0] = '{1'b1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 1, 32'h55AA_55AA, 1'b1, 32'hDEAD_BEEF, 4'hF, 3,  32'h0,         1'b0};
        vecs[1] = '{1'b0, 1'b0, 32'h8000_0000, 32'h0,         4'h0, 2, 32'h0000_0413, 1'b0, 32'h0,         4'h0, 4,  32'h0000_0413, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'h8000_2004, 32'h1234_5678, 4'h3, 3, 32'hCAFE_F00D, 1'b0, 32'h1234_5678, 4'h3, 5,  32'hCAFE_F00D, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 32'h8000_0010, 32'h0,         4'h0, 0, 32'h0,         1'b0, 32'h0,         4'h0, 65, 32'h0,         1'b1};
        vecs[4] = '{1'b1, 1'b0, 32'h8000_3000, 32'h7777_7777, 4'h8, 0, 32'h0,         1'b0, 32'h7777_7777, 4'h8, 65, 32'h0,         1'b1};
        vecs[5] = '{1'b0, 1'b0, 32'h8000_0020, 32'h0,         4'h0, 1, 32'hFFFF_FFFF, 1'b0, 32'h0,         4'h0, 3,  32'hFFFF_FFFF, 1'b0};

        // reset state
        #2 rst_n = 0;
        #1;
        chk("reset_mem_req", mem_req, 0);
        chk("reset_busy", busy, 0);
        chk("reset_rvalids", {ifu_rvalid, lsu_rvalid, ifu_err, lsu_err}, 0);
        chk("reset_rdata", {ifu_rdata, lsu_rdata}, 0);
        chk("reset_payload", {mem_wen, mem_addr, mem_wdata, mem_wmask}, 0);
        tick(); tick(); tick();
        rst_n = 1;
        tick();

        // ties: IFU wins the first after reset, LSU wins the next one
        for (int r = 0; r < 2; r++) begin
            logic [31:0] a_i, a_l, first, second;
            a_i = 32'h0000_1000 + 32'(r * 4);
            a_l = 32'h8000_2000 + 32'(r * 4);
            first  = (r == 0) ? a_i : a_l;
            second = (r == 0) ? a_l : a_i;
            ifu_req = 1; ifu_addr = a_i;
            lsu_req = 1; lsu_wen = 0; lsu_addr = a_l; lsu_wdata = 0; lsu_wmask = 0;
            tick(); ifu_req = 0; lsu_req = 0;
            chk($sformatf("tie%0d_first_req", r), mem_req, 1);
            chk($sformatf("tie%0d_first_addr", r), mem_addr, first);
            tick(); mem_rvalid = 1; mem_rdata = 32'h1111_0000 + 32'(r);
            tick(); mem_rvalid = 0;
            chk($sformatf("tie%0d_first_rvalid", r), (r == 0) ? ifu_rvalid : lsu_rvalid, 1);
            chk($sformatf("tie%0d_gap", r), mem_req, 0);
            tick();
            chk($sformatf("tie%0d_second_req", r), mem_req, 1);
            chk($sformatf("tie%0d_second_addr", r), mem_addr, second);
            tick(); mem_rvalid = 1; mem_rdata = 32'h2222_0000 + 32'(r);
            tick(); mem_rvalid = 0;
            chk($sformatf("tie%0d_second_rvalid", r), (r == 0) ? lsu_rvalid : ifu_rvalid, 1);
            chk($sformatf("tie%0d_second_rdata", r), (r == 0) ? lsu_rdata : ifu_rdata,
                32'h2222_0000 + 32'(r));
            tick();
        end

        // directed vector table; after each timeout, a late response must be ignored
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            if (vecs[i].lat == 0) begin
                mem_rvalid = 1; mem_rdata = 32'h5151_5151;
                tick(); mem_rvalid = 0;
                chk($sformatf("vec%0d_late_ignored", i),
                    {ifu_rvalid, lsu_rvalid, mem_req, busy}, 0);
                tick();
            end
        end

        // back-to-back: LSU store arrives during IFU WAIT (k=0) or together with mem_rvalid (k=1)
        for (int k = 0; k < 2; k++) begin
            ifu_req = 1; ifu_addr = 32'h0000_3000 + 32'(k * 4);
            tick(); ifu_req = 0;
            chk($sformatf("b2b%0d_ifu_req", k), mem_addr, 32'h0000_3000 + 32'(k * 4));
            lsu_wen = 1; lsu_addr = 32'h8000_3100 + 32'(k * 4);
            lsu_wdata = 32'h0A0B_0C00 + 32'(k); lsu_wmask = 4'h5;
            if (k == 0) lsu_req = 1;
            tick(); lsu_req = 0;
            if (k == 1) lsu_req = 1;
            mem_rvalid = 1; mem_rdata = 32'hABCD_0000 + 32'(k);
            tick(); lsu_req = 0; mem_rvalid = 0;
            chk($sformatf("b2b%0d_ifu_rvalid", k), ifu_rvalid, 1);
            chk($sformatf("b2b%0d_ifu_rdata", k), ifu_rdata, 32'hABCD_0000 + 32'(k));
            chk($sformatf("b2b%0d_gap", k), mem_req, 0);
            tick();
            chk($sformatf("b2b%0d_lsu_req", k), mem_req, 1);
            chk($sformatf("b2b%0d_lsu_payload", k), {mem_wen, mem_addr, mem_wdata, mem_wmask},
                {1'b1, 32'h8000_3100 + 32'(k * 4), 32'h0A0B_0C00 + 32'(k), 4'h5});
            tick(); mem_rvalid = 1; mem_rdata = 32'h9999_9999;
            tick(); mem_rvalid = 0;
            chk($sformatf("b2b%0d_lsu_rvalid", k), lsu_rvalid, 1);
            chk($sformatf("b2b%0d_store_rdata", k), lsu_rdata, 0);
            extra = 0;
            for (int j = 0; j < 6; j++) begin
                tick();
                extra += int'(ifu_rvalid) + int'(lsu_rvalid) + int'(mem_req);
            end
            chk($sformatf("b2b%0d_no_duplicates", k), extra, 0);
        end

        // reset while waiting abandons the request
        ifu_req = 1; ifu_addr = 32'h0000_4000;
        tick(); ifu_req = 0;
        chk("rstwait_mem_req", mem_req, 1);
        #1 rst_n = 0;
        #1;
        chk("rstwait_outputs", {mem_req, busy, ifu_rvalid, lsu_rvalid, ifu_err, lsu_err}, 0);
        chk("rstwait_data", {mem_addr, ifu_rdata, lsu_rdata}, 0);
        tick(); rst_n = 1;
        mem_rvalid = 1; mem_rdata = 32'h3333_3333;
        extra = 0;
        for (int j = 0; j < 8; j++) begin
            tick(); mem_rvalid = 0;
            extra += int'(ifu_rvalid) + int'(lsu_rvalid) + int'(mem_req);
        end
        chk("rstwait_no_rvalid", extra, 0);

        // randomized traffic against the transaction model
        for (int n = 0; n < 3000; n++) rnd_step(1'b1);
        for (int n = 0; n < 400 && (i_out || l_out); n++) rnd_step(1'b0);
        chk("rnd_drained", {i_out, l_out}, 0);
        chk("rnd_spurious", spurious, 0);
        chk("rnd_progress", n_done > 100, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width (mask width DATA_W/8).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64, maximum WAIT cycles before error completion.
REQ-004 SHALL have ports, one per line:
  clk  in  1  clock, all state on rising edge
  rst_n  in  1  asynchronous active-low reset
  ifu_req  in  1  one-cycle instruction-read request pulse
  ifu_addr  in  ADDR_W  fetch address
  ifu_rvalid  out  1  one-cycle completion pulse to IFU
  ifu_rdata  out  DATA_W  fetch data
  ifu_err  out  1  qualifies ifu_rvalid, timeout occurred
  lsu_req  in  1  one-cycle load/store request pulse
  lsu_wen  in  1  1=store, 0=load
  lsu_addr  in  ADDR_W  access address
  lsu_wdata  in  DATA_W  store data
  lsu_wmask  in  DATA_W/8  store byte enables
  lsu_rvalid  out  1  one-cycle completion pulse to LSU (loads and stores)
  lsu_rdata  out  DATA_W  load data (0 for stores)
  lsu_err  out  1  qualifies lsu_rvalid, timeout occurred
  mem_req  out  1  one-cycle request pulse to shared memory
  mem_wen, mem_addr, mem_wdata, mem_wmask  out  1/ADDR_W/DATA_W/DATA_W/8  registered request payload
  mem_rvalid  in  1  memory completion pulse
  mem_rdata  in  DATA_W  memory read data
  busy  out  1  high while state is WAIT

Function
REQ-005 SHALL implement FSM: IDLE, WAIT.
REQ-006 SHALL keep pending flags pend_ifu and pend_lsu, set by the matching req pulse, cleared when that master is granted.
REQ-007 SHALL, in IDLE, arbitrate among (req | pend) per master; on a winner, at that edge: mem_req<=1, payload from winner's inputs, owner<=winner, state<=WAIT.
REQ-008 SHALL grant the single contender directly; when both contend, grant the master not equal to last_owner (round-robin), then update last_owner.
REQ-009 SHALL drive mem_req high for exactly one cycle per grant; mem_wen=0, mem_wdata=0, mem_wmask=0 for IFU grants.
REQ-010 SHALL, in WAIT, on mem_rvalid: pulse owner's rvalid next cycle with rdata<=mem_rdata (0 for LSU stores), err=0, state<=IDLE.
REQ-011 SHALL count WAIT cycles; at TIMEOUT_CYCLES without mem_rvalid: pulse owner's rvalid with err=1, rdata=0, state<=IDLE.
REQ-012 SHALL ignore mem_rvalid in IDLE (late response after timeout).
REQ-013 Latency: req edge -> mem_req next cycle; mem_rvalid cycle t -> owner rvalid cycle t+1; earliest next mem_req cycle t+2.
REQ-014 Masters hold payload stable from req until their rvalid and issue one outstanding request; a req while own pend set SHALL be ignored.
REQ-015 A req arriving while WAIT SHALL only set pend; simultaneous mem_rvalid and other-master req SHALL both take effect.
REQ-016 rvalid/err outputs SHALL be single-cycle pulses; rdata holds last value between pulses.

Reset
REQ-017 SHALL, on rst_n low, immediately force: state=IDLE, all outputs 0, pend_*=0, counter=0, last_owner=LSU (IFU wins first tie).
REQ-018 Reset mid-WAIT SHALL abandon the transaction; no rvalid for it after release.

Structure
REQ-019 Package mem_arb_pkg SHALL hold state enum, owner enum {OWN_IFU, OWN_LSU}, default widths, default TIMEOUT_CYCLES.
REQ-020 Sub-module mem_arb_timer (clear/enable/expired, TIMEOUT_CYCLES) SHALL implement the WAIT counter.

Verification
REQ-021 IFU alone: ifu_req, addr 0x80000000, memory 2-cycle latency returns 0x00000413 -> mem_req 1 cycle later, ifu_rvalid 4 cycles after req, rdata 0x00000413, err 0.
REQ-022 Tie after reset: ifu_req and lsu_req same cycle -> IFU granted first, LSU mem_req 2 cycles after IFU mem_rvalid; repeat tie -> LSU granted first.
REQ-023 Store: lsu_req, wen 1, addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF -> mem payload matches, lsu_rvalid with rdata 0.
REQ-024 Timeout: memory never responds -> owner rvalid with err 1 exactly 64 WAIT cycles after mem_req; later mem_rvalid ignored.
REQ-025 Back-to-back: lsu_req during IFU WAIT -> pend_lsu held, LSU serviced next; no lost or duplicated completion.
REQ-026 Reset in WAIT: rst_n low 1 cycle -> all outputs 0, no rvalid for aborted request.
